// File: rtl/preimage_pkg.sv
// Shared widths and FSM state type for the preimage enumerator.
package preimage_pkg;
  localparam int ADDR_W = 6;
  localparam int TT_W   = 64;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/next_match_finder.sv
// Combinational priority search: lowest index >= start with tt[index] == y.
// start is one bit wider than an address so that "one past the top" means no candidates.
module next_match_finder
  import preimage_pkg::*;
(
  input  logic [TT_W-1:0]   tt,
  input  logic              y,
  input  logic [ADDR_W:0]   start,
  output logic              found,
  output logic [ADDR_W-1:0] idx
);

  // Walk downwards so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (i >= int'(start) && tt[i] == y) begin
        found = 1'b1;
        idx   = ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/preimage_enum.sv
// Enumerates every address x of a 6-input truth table with f(x) == requested y.
// Define PREIMAGE_SKIP_EN to jump straight to the next match instead of scanning linearly.
module preimage_enum
  import preimage_pkg::*;
#(
  parameter logic [TT_W-1:0] TT = 64'h8000_0000_0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   addr_q;
  logic                y_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                hit;
  logic                scan_end;
  logic [ADDR_W-1:0]   cand;
  logic                more_found;
  logic [ADDR_W-1:0]   more_idx_unused;

`ifdef PREIMAGE_SKIP_EN
  next_match_finder u_skip (
    .tt    (TT),
    .y     (y_q),
    .start ({1'b0, ptr}),
    .found (hit),
    .idx   (cand)
  );
  // A failed priority search means nothing is left anywhere above ptr.
  assign scan_end = 1'b1;
`else
  assign hit      = (TT[ptr] == y_q);
  assign cand     = ptr;
  assign scan_end = (ptr == ADDR_W'(TT_W - 1));
`endif

  // Anything matching above the candidate decides whether this emit is the last one.
  next_match_finder u_last (
    .tt    (TT),
    .y     (y_q),
    .start ({1'b0, cand} + 7'd1),
    .found (more_found),
    .idx   (more_idx_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_SCAN;
      S_SCAN: begin
        if (hit)           state_nxt = S_EMIT;
        else if (scan_end) state_nxt = S_DONE;
      end
      S_EMIT: if (out_ready) state_nxt = last_q ? S_DONE : S_SCAN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    out_valid = (state == S_EMIT);
    out_last  = (state == S_EMIT) && last_q;
    done      = (state == S_DONE);
    out_addr  = addr_q;
    match_cnt = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      addr_q <= '0;
      y_q    <= 1'b0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          y_q   <= req_y;
          cnt_q <= '0;
          ptr   <= '0;
        end
        S_SCAN: begin
          if (hit) begin
            addr_q <= cand;
            last_q <= !more_found;
          end else begin
            ptr <= ptr + 6'd1;
          end
        end
        S_EMIT: if (out_ready) begin
          cnt_q <= cnt_q + 7'd1;
          ptr   <= addr_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preimage_enum.sv
// Scoreboard bench for preimage_enum: three instances (default TT, all zeros, all ones).
module tb_preimage_enum;

  typedef struct packed {
    logic [1:0] dut;
    logic [5:0] addr;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_y = '0;
  logic [2:0] out_ready = '1;
  logic [2:0] req_ready;
  logic [2:0] out_valid;
  logic [2:0] out_last;
  logic [2:0] done;
  logic [5:0] out_addr [3];
  logic [6:0] match_cnt [3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [63:0] TTG = (g == 0) ? 64'h8000_0000_0000_0001 :
                                  (g == 1) ? 64'h0 : {64{1'b1}};
    preimage_enum #(.TT(TTG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_y     (req_y[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_addr  (out_addr[g]),
      .out_last  (out_last[g]),
      .done      (done[g]),
      .match_cnt (match_cnt[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int addr, input bit last);
    exp_t e;
    e.dut  = 2'(d);
    e.addr = 6'(addr);
    e.last = last;
    sb.push_back(e);
  endtask

  // Monitor: every output handshake is matched against the oldest expected emit.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && req_valid[d] && req_ready[d]) acc[d]++;
      if (rst_n && out_valid[d] && out_ready[d]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL emit_unexpected dut %0d got addr %0d expected no output", d, out_addr[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (int'(e.dut) != d || e.addr !== out_addr[d] || e.last !== out_last[d]) begin
            errors++;
            $display("FAIL emit dut %0d got addr %0d last %0d expected dut %0d addr %0d last %0d",
                     d, out_addr[d], out_last[d], e.dut, e.addr, e.last);
          end
        end
      end
    end
  end

  task automatic wait_done(input int d, input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done[d]) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic finish_query(input int d, input int exp_cnt, input string name);
    chk({name, "_cnt"}, int'(match_cnt[d]), exp_cnt);
    chk({name, "_sb_empty"}, sb.size(), 0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, int'(done[d]), 0);
    chk({name, "_ready_back"}, int'(req_ready[d]), 1);
    chk({name, "_cnt_hold"}, int'(match_cnt[d]), exp_cnt);
  endtask

  task automatic run_query(input int d, input logic y, input int exp_cnt, input string name);
    @(posedge clk); #1;
    req_valid[d] = 1'b1;
    req_y[d]     = y;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    wait_done(d, 300, name);
    finish_query(d, exp_cnt, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros_seen;
    bit found;

    // Reset values while rst_n is low.
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready", int'(req_ready[d]), 1);
      chk("rst_out_valid", int'(out_valid[d]), 0);
      chk("rst_out_last", int'(out_last[d]), 0);
      chk("rst_done", int'(done[d]), 0);
      chk("rst_out_addr", int'(out_addr[d]), 0);
      chk("rst_match_cnt", int'(match_cnt[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Default TT, y=1: addresses 0 and 63.
    push(0, 0, 1'b0);
    push(0, 63, 1'b1);
    run_query(0, 1'b1, 2, "y1");

    // Default TT, y=0: addresses 1..62.
    for (int a = 1; a <= 62; a++) push(0, a, a == 62);
    run_query(0, 1'b0, 62, "y0");

    // TT all zeros, y=1: nothing emitted.
    run_query(1, 1'b1, 0, "none");

    // Back-pressure: first match held for 5 cycles, with k+1 = 1 cycle latency.
    out_ready[0] = 1'b0;
    push(0, 0, 1'b0);
    push(0, 63, 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_y[0]     = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lat_scan_no_valid", int'(out_valid[0]), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid[0]), 1);
      chk("stall_addr", int'(out_addr[0]), 0);
      chk("stall_last", int'(out_last[0]), 0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_done(0, 300, "stall");
    finish_query(0, 2, "stall");

    // Reset in the middle of a y=0 scan aborts it for good.
    for (int a = 1; a <= 62; a++) push(0, a, a == 62);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_y[0]     = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n >= 8 && !out_valid[0] && !done[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_found_scan", int'(found), 1);
    chk("abort_cnt_nonzero", int'(match_cnt[0] != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", int'(req_ready[0]), 1);
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_out_last", int'(out_last[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_out_addr", int'(out_addr[0]), 0);
    chk("abort_match_cnt", int'(match_cnt[0]), 0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    zeros_seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (out_valid[0] || done[0] || !req_ready[0]) zeros_seen++;
    end
    chk("abort_no_resume", zeros_seen, 0);
    push(0, 0, 1'b0);
    push(0, 63, 1'b1);
    run_query(0, 1'b1, 2, "after_rst");

    // req_valid held high through the whole all-ones query.
    for (int a = 0; a <= 63; a++) push(2, a, a == 63);
    acc[2] = 0;
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_y[2]     = 1'b1;
    wait_done(2, 400, "hold");
    req_valid[2] = 1'b0;
    chk("hold_accepts", acc[2], 1);
    finish_query(2, 64, "hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
